// File: rtl/bcd_display_mux_2digit.sv
// Two-digit multiplexed 7-segment driver.
// Holds a BCD pair captured on a load strobe and alternates the two digits
// onto one shared segment bus. Each digit phase begins with a blank guard
// cycle so the previous digit's pattern never ghosts onto the next anode.
// Anodes are always active-low; segment polarity is selectable.
//
// Handshake: load is a fire-and-forget strobe with no ready. Whenever load
// is high at a rising edge, units/tens are captured; when load is low the
// digit inputs are ignored. There is no back-pressure and a load never
// disturbs the refresh timing.
module bcd_display_mux_2digit #(
  parameter int REFRESH_DIV    = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] units,
  input  logic [3:0] tens,
  input  logic       load,
  input  logic       blank_zero,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int              CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]      SEG_OFF  = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
  localparam logic [1:0]      AN_OFF   = 2'b11;
  localparam logic [1:0]      AN_UNITS = 2'b10;
  localparam logic [1:0]      AN_TENS  = 2'b01;

  typedef enum logic {
    PH_UNITS = 1'b0,
    PH_TENS  = 1'b1
  } phase_e;

  // Phase state and position within the phase
  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Captured digits
  logic [3:0] held_units_q, held_units_d;
  logic [3:0] held_tens_q, held_tens_d;

  // Registered pin drivers
  logic [6:0] seg_q, seg_d;
  logic [1:0] an_q, an_d;

  // Output-stage helpers
  logic [3:0] digit_sel;
  logic [6:0] pattern;
  logic       guard_cycle;
  logic       suppress_tens;

  // Active-high segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1101111;
      default: p = 7'b1000000;
    endcase
    return p;
  endfunction

  // Phase state register; reset restarts at the UNITS guard position
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= PH_UNITS;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next phase: count through the phase, toggle the digit on wrap
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q + 1'b1;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = (phase_q == PH_UNITS) ? PH_TENS : PH_UNITS;
    end
  end

  // Held digit registers
  always_ff @(posedge clk) begin
    if (reset) begin
      held_units_q <= '0;
      held_tens_q  <= '0;
    end else begin
      held_units_q <= held_units_d;
      held_tens_q  <= held_tens_d;
    end
  end

  // Capture new digits only on a load strobe
  always_comb begin
    held_units_d = held_units_q;
    held_tens_d  = held_tens_q;
    if (load) begin
      held_units_d = units;
      held_tens_d  = tens;
    end
  end

  // Output decode: guard cycle and leading-zero suppression blank the bus
  always_comb begin
    digit_sel     = (phase_q == PH_TENS) ? held_tens_q : held_units_q;
    pattern       = bcd_to_seg(digit_sel);
    guard_cycle   = (cnt_q == '0);
    suppress_tens = (phase_q == PH_TENS) && blank_zero && (held_tens_q == 4'd0);
    seg_d         = SEG_OFF;
    an_d          = AN_OFF;
    if (!guard_cycle && !suppress_tens) begin
      an_d  = (phase_q == PH_TENS) ? AN_TENS : AN_UNITS;
      seg_d = SEG_ACTIVE_LOW ? ~pattern : pattern;
    end
  end

  // Registered pins; reset turns every anode and segment off
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule
